// File: rtl/lp_filter_tdm_sched_pkg.sv
// Shared limits, FSM encoding and width helper for the TDM lowpass filter scheduler.
package lp_filter_tdm_sched_pkg;

    localparam int STAGE_COUNT_MAX = 5;
    localparam int CHANNELS_MAX    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lp_ema_update.sv
// Single EMA stage, purely combinational: acc' = acc + x - acc/2^SHIFT, y = floor(acc'/2^SHIFT).
// Output range is bounded by |x| so y always fits OUT_BITS without saturation.
module lp_ema_update #(
    parameter int OUT_BITS   = 28,
    parameter int SHIFT_BITS = 5
) (
    input  logic signed [OUT_BITS+SHIFT_BITS-1:0] acc,
    input  logic signed [OUT_BITS-1:0]            x,
    output logic signed [OUT_BITS+SHIFT_BITS-1:0] acc_next,
    output logic signed [OUT_BITS-1:0]            y
);

    localparam int ACC_BITS = OUT_BITS + SHIFT_BITS;

    logic signed [ACC_BITS-1:0] x_ext;
    logic signed [ACC_BITS-1:0] acc_new;

    assign x_ext    = ACC_BITS'(x);
    assign acc_new  = acc + x_ext - (acc >>> SHIFT_BITS);
    assign acc_next = acc_new;
    assign y        = OUT_BITS'(acc_new >>> SHIFT_BITS);

endmodule

// File: rtl/lp_filter_tdm_sched.sv
// Round-robin TDM scheduler running STAGE_COUNT cascaded EMA stages on one shared datapath.
// Latency STAGE_COUNT+1 edges from capture; no backpressure, late samples overwrite and flag OVERRUN.
module lp_filter_tdm_sched
    import lp_filter_tdm_sched_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int IN_DATA_BITS  = 28,
    parameter int OUT_DATA_BITS = 28,
    parameter int SHIFT_BITS    = 5,
    parameter int STAGE_COUNT   = 2,
    localparam int CH_BITS      = (clog2(CHANNELS) > 0) ? clog2(CHANNELS) : 1
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                CE,
    input  logic [CHANNELS*IN_DATA_BITS-1:0]    IN_VALUE,
    input  logic [CHANNELS-1:0]                 IN_VALID,
    input  logic [CHANNELS-1:0]                 OVR_CLEAR,
    output logic signed [OUT_DATA_BITS-1:0]     OUT_VALUE,
    output logic [CH_BITS-1:0]                  OUT_CHANNEL,
    output logic                                OUT_VALID,
    output logic                                BUSY,
    output logic [CHANNELS-1:0]                 OVERRUN
);

    localparam int ST_BITS  = (clog2(STAGE_COUNT) > 0) ? clog2(STAGE_COUNT) : 1;
    localparam int ACC_BITS = OUT_DATA_BITS + SHIFT_BITS;

    generate
        if (STAGE_COUNT < 1 || STAGE_COUNT > STAGE_COUNT_MAX) begin : g_bad_stage_count
            $error("lp_filter_tdm_sched: STAGE_COUNT must be within 1..5");
        end
        if (CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_channels
            $error("lp_filter_tdm_sched: CHANNELS must be within 1..16");
        end
        if (OUT_DATA_BITS < IN_DATA_BITS) begin : g_bad_widths
            $error("lp_filter_tdm_sched: OUT_DATA_BITS must be >= IN_DATA_BITS");
        end
    endgenerate

    state_t                      state;
    logic [CH_BITS-1:0]          rr_ptr;
    logic [CH_BITS-1:0]          cur_ch;
    logic [ST_BITS-1:0]          stage;
    logic [CHANNELS-1:0]         pending;
    logic signed [OUT_DATA_BITS-1:0] hold [CHANNELS];
    logic signed [OUT_DATA_BITS-1:0] x_reg;
    logic signed [ACC_BITS-1:0]  acc [CHANNELS][STAGE_COUNT];

    logic signed [OUT_DATA_BITS-1:0] in_aligned [CHANNELS];
    logic [CHANNELS-1:0]         pend_rot;
    logic                        grant_vld;
    logic [CH_BITS-1:0]          grant_off;
    logic [CH_BITS:0]            grant_sum;
    logic [CH_BITS-1:0]          grant_ch;
    logic [CHANNELS-1:0]         grant_onehot;
    logic [CHANNELS-1:0]         ovr_set;

    logic signed [ACC_BITS-1:0]  acc_cur;
    logic signed [ACC_BITS-1:0]  acc_next;
    logic signed [OUT_DATA_BITS-1:0] y;

    // Samples are left-aligned so narrower inputs keep full output-scale resolution.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_align
        assign in_aligned[c] = OUT_DATA_BITS'($signed(IN_VALUE[c*IN_DATA_BITS +: IN_DATA_BITS]))
                               <<< (OUT_DATA_BITS - IN_DATA_BITS);
    end

    // Rotate so bit 0 is rr_ptr; the lowest set bit is the next channel in round-robin order.
    always_comb begin
        pend_rot  = CHANNELS'({pending, pending} >> rr_ptr);
        grant_vld = 1'b0;
        grant_off = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_rot[i]) begin
                grant_vld = 1'b1;
                grant_off = CH_BITS'(i);
            end
        end
    end

    assign grant_sum    = {1'b0, rr_ptr} + {1'b0, grant_off};
    assign grant_ch     = (grant_sum >= (CH_BITS+1)'(CHANNELS))
                          ? CH_BITS'(grant_sum - (CH_BITS+1)'(CHANNELS))
                          : CH_BITS'(grant_sum);
    assign grant_onehot = (state == ST_IDLE && grant_vld) ? (CHANNELS'(1) << grant_ch) : '0;
    assign ovr_set      = IN_VALID & pending & ~grant_onehot;

    assign acc_cur = acc[cur_ch][stage];

    lp_ema_update #(
        .OUT_BITS   (OUT_DATA_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_ema (
        .acc      (acc_cur),
        .x        (x_reg),
        .acc_next (acc_next),
        .y        (y)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            cur_ch      <= '0;
            stage       <= '0;
            pending     <= '0;
            x_reg       <= '0;
            OUT_VALUE   <= '0;
            OUT_CHANNEL <= '0;
            OUT_VALID   <= 1'b0;
            BUSY        <= 1'b0;
            OVERRUN     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hold[c] <= '0;
                for (int s = 0; s < STAGE_COUNT; s++) begin
                    acc[c][s] <= '0;
                end
            end
        end else if (CE) begin
            OUT_VALID <= 1'b0;
            pending   <= IN_VALID | (pending & ~grant_onehot);
            OVERRUN   <= ovr_set | (OVERRUN & ~OVR_CLEAR);
            for (int c = 0; c < CHANNELS; c++) begin
                if (IN_VALID[c]) begin
                    hold[c] <= in_aligned[c];
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        cur_ch <= grant_ch;
                        x_reg  <= hold[grant_ch];
                        rr_ptr <= (grant_ch == CH_BITS'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
                        stage  <= '0;
                        state  <= ST_RUN;
                        BUSY   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // x_reg carries this stage's output forward as the next stage's input.
                    acc[cur_ch][stage] <= acc_next;
                    x_reg              <= y;
                    if (stage == ST_BITS'(STAGE_COUNT - 1)) begin
                        state       <= ST_IDLE;
                        BUSY        <= 1'b0;
                        OUT_VALUE   <= y;
                        OUT_CHANNEL <= cur_ch;
                        OUT_VALID   <= 1'b1;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
